cell_chain_feeder: RTL

Source end of the weight-compute cell chain: accepts quantised input values from an upstream valid/ready stream, buffers them, and drives the chain's first cell with the index/value/enable protocol (index 0..VECTOR_LENGTH-1 per vector, enable low on idle cycles). Uses the tagged results returned from the chain's last cell as credits, so the chain never holds more finished vectors than its per-cell pending-result storage can absorb.

---
 rtl/chain_pkg.sv | 27 ++
 rtl/feeder_fifo.sv | 69 ++++++
 rtl/cell_chain_feeder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/chain_pkg.sv
// Shared definitions for the weight-compute cell chain: default widths,
// the idle word driven on cycles without an element, the result-valid bit
// position and the feeder FSM state type.
package chain_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int INDEX_WIDTH      = 10;
  localparam int RESULT_WIDTH     = 16;
  // The last cell flags a finished vector in the bit just above the result.
  localparam int RESULT_VALID_BIT = RESULT_WIDTH;

  // One element as seen by the first cell of the chain.
  typedef struct packed {
    logic                   enable;
    logic [INDEX_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0]  value;
  } cell_word_t;

  // Word driven whenever no element is issued.
  localparam cell_word_t IDLE_WORD = '{enable: 1'b0, index: '0, value: '0};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous input buffer for the chain feeder. The head entry is readable
// combinationally so a word written at one edge can be popped and registered
// downstream at the very next edge. Status flags are kept as registers.
module feeder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       not_full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, not_full_q, empty_q;
  logic             do_push, do_pop;

  // Guard against misuse: never write when full, never read when empty.
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;
  assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      not_full_q <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q    <= count_d;
      full_q     <= (count_d == (AW+1)'(DEPTH));
      not_full_q <= (count_d != (AW+1)'(DEPTH));
      empty_q    <= (count_d == '0);
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign not_full_o = not_full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;

endmodule

// File: rtl/cell_chain_feeder.sv
// Source end of the cell chain: buffers upstream values, issues them to the
// first cell as index/value/enable elements, and limits the number of
// vectors in the chain using returned results as credits.
module cell_chain_feeder #(
  parameter int DATA_WIDTH    = chain_pkg::DATA_WIDTH,
  parameter int INDEX_WIDTH   = chain_pkg::INDEX_WIDTH,
  parameter int VECTOR_LENGTH = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_INFLIGHT  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0]  out_value,
  output logic                   out_enable,
  input  logic                   ret_valid,
  output logic                   busy,
  output logic                   credit_err
);

  import chain_pkg::*;

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e          state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [INDEX_WIDTH-1:0] issue_idx;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic                   credit_err_q, credit_err_d;
  logic                   busy_q;
  logic                   out_enable_q;
  logic [INDEX_WIDTH-1:0] out_index_q;
  logic [DATA_WIDTH-1:0]  out_value_q;

  logic                   fifo_full, fifo_not_full, fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_rd_data;
  logic [FW-1:0]          fifo_count, fifo_count_d;
  logic                   push, pop, start, last, ret_ok;

  assign push = in_valid & fifo_not_full;

  feeder_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .wr_data_i  (in_data),
    .pop_i      (pop),
    .rd_data_o  (fifo_rd_data),
    .full_o     (fifo_full),
    .not_full_o (fifo_not_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Issue decision, next index, credit accounting and next occupancy.
  always_comb begin
    // A new vector needs a credit; a vector already under way never does.
    start     = (state_q == ST_IDLE) && !fifo_empty &&
                (inflight_q < CW'(MAX_INFLIGHT));
    pop       = start || ((state_q == ST_ISSUE) && !fifo_empty);
    issue_idx = (state_q == ST_IDLE) ? '0 : idx_q;
    last      = (state_q == ST_IDLE) ? (VECTOR_LENGTH == 1)
                                     : (idx_q == INDEX_WIDTH'(VECTOR_LENGTH - 1));
    state_d   = state_q;
    idx_d     = idx_q;
    if (pop) begin
      if (last) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        state_d = ST_ISSUE;
        idx_d   = issue_idx + 1'b1;
      end
    end
    // A return with nothing outstanding is a protocol error, not an underflow.
    ret_ok       = ret_valid && (inflight_q != '0);
    inflight_d   = inflight_q + CW'(start) - CW'(ret_ok);
    credit_err_d = credit_err_q || (ret_valid && (inflight_q == '0));
    fifo_count_d = fifo_count + FW'(push) - FW'(pop);
  end

  // FSM state, held index and credit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      inflight_q   <= '0;
      credit_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      inflight_q   <= inflight_d;
      credit_err_q <= credit_err_d;
      busy_q       <= (fifo_count_d != '0) || (state_d == ST_ISSUE) ||
                      (inflight_d != '0);
    end
  end

  // Registered element word to the first cell; idle word when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_enable_q <= IDLE_WORD.enable;
      out_index_q  <= INDEX_WIDTH'(IDLE_WORD.index);
      out_value_q  <= DATA_WIDTH'(IDLE_WORD.value);
    end else if (pop) begin
      out_enable_q <= 1'b1;
      out_index_q  <= issue_idx;
      out_value_q  <= fifo_rd_data;
    end else begin
      out_enable_q <= IDLE_WORD.enable;
      out_index_q  <= INDEX_WIDTH'(IDLE_WORD.index);
      out_value_q  <= DATA_WIDTH'(IDLE_WORD.value);
    end
  end

  assign in_ready   = fifo_not_full;
  assign out_enable = out_enable_q;
  assign out_index  = out_index_q;
  assign out_value  = out_value_q;
  assign busy       = busy_q;
  assign credit_err = credit_err_q;

endmodule
